// File: rtl/data_cache_arbiter.sv
// ============================================================================
// data_cache_arbiter: two-requester arbiter in front of a single cache port.
// Optional round-robin tie-break via macro DATA_CACHE_ARB_RR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_cache_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [DATA_WIDTH-1:0] c_write_data,
  output logic                  c_memwrite,
  output logic                  c_enable,
  input  logic [DATA_WIDTH-1:0] c_read_data,
  input  logic                  c_read_finished,
  input  logic                  c_write_finished
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             owner;       // 1 = port 1 holds the current access
  logic             tout_flag;
  logic [CNT_W-1:0] cnt;
  logic             tie_pick1;
  logic             pick1;
  logic             grant_now;
  logic             finish_hit;
  logic             expire;

  assign grant_now  = (state == ST_IDLE) && (req0 || req1);
  assign pick1      = req1 && (!req0 || tie_pick1);
  assign finish_hit = c_memwrite ? c_write_finished : c_read_finished;
  assign expire     = (cnt == CNT_LAST);

`ifdef DATA_CACHE_ARB_RR_EN
  // Reset value means "port 0 served last", so port 1 wins the first tie.
  logic last_served;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served <= 1'b0;
    end else if (grant_now) begin
      last_served <= pick1;
    end
  end

  assign tie_pick1 = ~last_served;
`else
  assign tie_pick1 = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    c_enable   = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (grant_now) next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        c_enable   = 1'b1;
        gnt0       = ~owner;
        gnt1       = owner;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        c_enable = 1'b1;
        if (finish_hit || expire) next_state = ST_DONE;
      end
      ST_DONE: begin
        done0      = ~owner;
        done1      = owner;
        timeout    = tout_flag;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Command and response datapath; command fields hold until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner        <= 1'b0;
      c_memwrite   <= 1'b0;
      c_addr       <= '0;
      c_write_data <= '0;
      rdata        <= '0;
      tout_flag    <= 1'b0;
      cnt          <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant_now) begin
            owner        <= pick1;
            c_memwrite   <= pick1 ? we1 : we0;
            c_addr       <= pick1 ? addr1 : addr0;
            c_write_data <= pick1 ? wdata1 : wdata0;
            tout_flag    <= 1'b0;
          end
        end
        ST_ISSUE: begin
          cnt <= '0;
        end
        ST_WAIT: begin
          if (finish_hit) begin
            if (!c_memwrite) rdata <= c_read_data;
          end else if (expire) begin
            tout_flag <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
